// File: rtl/seq_ctrl_pkg.sv
// Shared types and defaults for the program sequencer controller.
// Holds the opcode and FSM state encodings used by seq_controller.
package seq_ctrl_pkg;

  localparam int ADDR_W_DEF     = 4;
  localparam int LOOP_W_DEF     = 4;
  localparam int RST_CYCLES_DEF = 2;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_JMP  = 4'h1,
    OP_JNZ  = 4'h2,
    OP_LOOP = 4'h3,
    OP_LJ   = 4'h4,
    OP_HALT = 4'h5,
    OP_SRST = 4'h6
  } opcode_e;

  typedef enum logic [1:0] {
    ST_RST_SEQ = 2'd0,
    ST_RUN     = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_loop_cnt.sv
// Loop counter for LOOP/LJ: load, saturating decrement, zero detect.
// Clear has priority over load, load over decrement.
module seq_loop_cnt
  import seq_ctrl_pkg::*;
#(
  parameter int LOOP_W = LOOP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              dec,
  input  logic [LOOP_W-1:0] load_val,
  output logic              zero
);

  logic [LOOP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr:  cnt_d = '0;
      load: cnt_d = load_val;
      dec:  if (cnt_q != '0) cnt_d = cnt_q - LOOP_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_controller.sv
// Program sequencer controller: decodes instr into registered jump strobes.
// Define SEQ_CTRL_LOOP_EN to enable the LOOP/LJ opcodes and loop counter.
module seq_controller
  import seq_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LOOP_W     = LOOP_W_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instr,
  input  logic              instr_valid,
  input  logic              z_flag,
  input  logic              start,
  output logic              sync_reset,
  output logic              jmp,
  output logic              jmp_nz,
  output logic              dont_jmp,
  output logic [ADDR_W-1:0] jmp_addr,
  output logic              halted,
  output logic              illegal
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

  if (LOOP_W < 4) begin : g_loop_w_chk
    $error("LOOP_W must hold a 4-bit operand");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              sync_q, sync_d;
  logic              jmp_q, jmp_d;
  logic              jnz_q, jnz_d;
  logic              dj_q, dj_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              halt_q, halt_d;
  logic              ill_q, ill_d;

  logic [3:0] op;
  logic [3:0] opnd;

  assign op   = instr[7:4];
  assign opnd = instr[3:0];

`ifdef SEQ_CTRL_LOOP_EN
  logic lc_clr, lc_load, lc_dec, lc_zero;

  seq_loop_cnt #(
    .LOOP_W (LOOP_W)
  ) u_loop_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (lc_clr),
    .load     (lc_load),
    .dec      (lc_dec),
    .load_val (LOOP_W'(opnd)),
    .zero     (lc_zero)
  );
`endif

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    sync_d  = 1'b0;
    jmp_d   = 1'b0;
    jnz_d   = 1'b0;
    dj_d    = 1'b0;
    addr_d  = addr_q;
    halt_d  = 1'b0;
    ill_d   = 1'b0;
`ifdef SEQ_CTRL_LOOP_EN
    lc_clr  = 1'b0;
    lc_load = 1'b0;
    lc_dec  = 1'b0;
`endif
    unique case (state_q)
      ST_RST_SEQ: begin
        if (rcnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
          sync_d = 1'b1;
          dj_d   = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
        dj_d    = 1'b1;
      end
      ST_HALTED: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          halt_d = 1'b1;
          dj_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!instr_valid) begin
          dj_d = 1'b1;
        end else begin
          unique case (op)
            OP_NOP: ;
            OP_JMP: begin
              jmp_d   = 1'b1;
              addr_d  = ADDR_W'(opnd);
              state_d = ST_FLUSH;
            end
            OP_JNZ: begin
              jnz_d  = 1'b1;
              addr_d = ADDR_W'(opnd);
              if (!z_flag) state_d = ST_FLUSH;
            end
`ifdef SEQ_CTRL_LOOP_EN
            OP_LOOP: lc_load = 1'b1;
            OP_LJ: begin
              if (!lc_zero) begin
                lc_dec  = 1'b1;
                jmp_d   = 1'b1;
                addr_d  = ADDR_W'(opnd);
                state_d = ST_FLUSH;
              end
            end
`endif
            OP_HALT: begin
              state_d = ST_HALTED;
              halt_d  = 1'b1;
              dj_d    = 1'b1;
            end
            OP_SRST: begin
              state_d = ST_RST_SEQ;
              rcnt_d  = '0;
              sync_d  = 1'b1;
              dj_d    = 1'b1;
`ifdef SEQ_CTRL_LOOP_EN
              lc_clr  = 1'b1;
`endif
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST_SEQ;
      rcnt_q  <= '0;
      sync_q  <= 1'b1;
      jmp_q   <= 1'b0;
      jnz_q   <= 1'b0;
      dj_q    <= 1'b1;
      addr_q  <= '0;
      halt_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      sync_q  <= sync_d;
      jmp_q   <= jmp_d;
      jnz_q   <= jnz_d;
      dj_q    <= dj_d;
      addr_q  <= addr_d;
      halt_q  <= halt_d;
      ill_q   <= ill_d;
    end
  end

  assign sync_reset = sync_q;
  assign jmp        = jmp_q;
  assign jmp_nz     = jnz_q;
  assign dont_jmp   = dj_q;
  assign jmp_addr   = addr_q;
  assign halted     = halt_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller (RST_CYCLES=2, ADDR_W=4).
// Expected outputs are queued with each stimulus and popped after the edge.
module tb_seq_controller;

  typedef struct packed {
    logic       sync;
    logic       jmp;
    logic       jnz;
    logic       dj;
    logic [3:0] addr;
    logic       hlt;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic [7:0] i;
    logic       v;
    logic       z;
    logic       s;
    out_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       z_flag = 1'b0;
  logic       start = 1'b0;
  logic       sync_reset, jmp, jmp_nz, dont_jmp, halted, illegal;
  logic [3:0] jmp_addr;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] a = 4'h0;
  out_t       sb[$];

  always #5 clk = ~clk;

  seq_controller #(
    .ADDR_W     (4),
    .LOOP_W     (4),
    .RST_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .z_flag      (z_flag),
    .start       (start),
    .sync_reset  (sync_reset),
    .jmp         (jmp),
    .jmp_nz      (jmp_nz),
    .dont_jmp    (dont_jmp),
    .jmp_addr    (jmp_addr),
    .halted      (halted),
    .illegal     (illegal)
  );

  function automatic out_t mk(logic sy, logic j, logic jn, logic d,
                              logic [3:0] ad, logic h, logic il);
    out_t o;
    o = '{sync: sy, jmp: j, jnz: jn, dj: d, addr: ad, hlt: h, ill: il};
    return o;
  endfunction

  function automatic vec_t V(logic [7:0] i, logic v, logic z, logic s,
                             out_t e);
    vec_t t;
    t = '{i: i, v: v, z: z, s: s, e: e};
    return t;
  endfunction

  function automatic out_t obs();
    return mk(sync_reset, jmp, jmp_nz, dont_jmp, jmp_addr, halted, illegal);
  endfunction

  task automatic apply(input vec_t t);
    instr       = t.i;
    instr_valid = t.v;
    z_flag      = t.z;
    start       = t.s;
    sb.push_back(t.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t t[$];
    out_t got, exp;
    instr       = 8'h1A;
    instr_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      got = obs();
      checks++;
      if (got !== mk(1, 0, 0, 1, 4'h0, 0, 0)) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got %b want %b", k, got,
                 mk(1, 0, 0, 1, 4'h0, 0, 0));
      end
    end
    reset = 1'b0;
    t.push_back(V(8'h1F, 1, 0, 0, mk(1, 0, 0, 1, 4'h0, 0, 0)));
    t.push_back(V(8'h1F, 1, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 0)));
    t.push_back(V(8'h00, 1, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 0)));
    t.push_back(V(8'h00, 0, 0, 0, mk(0, 0, 0, 1, 4'h0, 0, 0)));
    foreach (t[k]) begin
      apply(t[k]);
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rst_seq step %0d got %b want %b", k, got, exp);
      end
    end
    a = 4'h0;
  endtask

  task automatic test_jmp();
    vec_t t[$];
    out_t got, exp;
    t.push_back(V(8'h1A, 1, 0, 0, mk(0, 1, 0, 0, 4'hA, 0, 0)));
    t.push_back(V(8'h1B, 1, 0, 0, mk(0, 0, 0, 1, 4'hA, 0, 0)));
    t.push_back(V(8'h00, 1, 0, 0, mk(0, 0, 0, 0, 4'hA, 0, 0)));
    t.push_back(V(8'h15, 1, 0, 0, mk(0, 1, 0, 0, 4'h5, 0, 0)));
    t.push_back(V(8'h1B, 0, 0, 0, mk(0, 0, 0, 1, 4'h5, 0, 0)));
    t.push_back(V(8'h00, 1, 0, 0, mk(0, 0, 0, 0, 4'h5, 0, 0)));
    foreach (t[k]) begin
      apply(t[k]);
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL jmp step %0d got %b want %b", k, got, exp);
      end
    end
    a = 4'h5;
  endtask

  task automatic test_jnz();
    vec_t t[$];
    out_t got, exp;
    t.push_back(V(8'h27, 1, 0, 0, mk(0, 0, 1, 0, 4'h7, 0, 0)));
    t.push_back(V(8'h11, 1, 0, 0, mk(0, 0, 0, 1, 4'h7, 0, 0)));
    t.push_back(V(8'h27, 1, 1, 0, mk(0, 0, 1, 0, 4'h7, 0, 0)));
    t.push_back(V(8'h13, 1, 0, 0, mk(0, 1, 0, 0, 4'h3, 0, 0)));
    t.push_back(V(8'h00, 1, 0, 0, mk(0, 0, 0, 1, 4'h3, 0, 0)));
    t.push_back(V(8'h00, 1, 0, 0, mk(0, 0, 0, 0, 4'h3, 0, 0)));
    foreach (t[k]) begin
      apply(t[k]);
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL jnz step %0d got %b want %b", k, got, exp);
      end
    end
    a = 4'h3;
  endtask

  task automatic test_loop();
    vec_t t[$];
    out_t got, exp;
`ifdef SEQ_CTRL_LOOP_EN
    t.push_back(V(8'h33, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 0)));
    for (int n = 0; n < 3; n++) begin
      t.push_back(V(8'h42, 1, 0, 0, mk(0, 1, 0, 0, 4'h2, 0, 0)));
      t.push_back(V(8'h42, 1, 0, 0, mk(0, 0, 0, 1, 4'h2, 0, 0)));
    end
    t.push_back(V(8'h42, 1, 0, 0, mk(0, 0, 0, 0, 4'h2, 0, 0)));
    t.push_back(V(8'h42, 1, 0, 0, mk(0, 0, 0, 0, 4'h2, 0, 0)));
    a = 4'h2;
`else
    t.push_back(V(8'h33, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 1)));
    t.push_back(V(8'h42, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 1)));
    t.push_back(V(8'h00, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 0)));
`endif
    foreach (t[k]) begin
      apply(t[k]);
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL loop step %0d got %b want %b", k, got, exp);
      end
    end
  endtask

  task automatic test_halt();
    vec_t t[$];
    out_t got, exp;
    t.push_back(V(8'h50, 1, 0, 0, mk(0, 0, 0, 1, a, 1, 0)));
    for (int n = 0; n < 10; n++)
      t.push_back(V(8'h1F, 1, 0, 0, mk(0, 0, 0, 1, a, 1, 0)));
    t.push_back(V(8'h1F, 1, 0, 1, mk(0, 0, 0, 0, a, 0, 0)));
    t.push_back(V(8'h00, 1, 0, 1, mk(0, 0, 0, 0, a, 0, 0)));
    t.push_back(V(8'h2E, 1, 1, 0, mk(0, 0, 1, 0, 4'hE, 0, 0)));
    t.push_back(V(8'h00, 1, 0, 0, mk(0, 0, 0, 0, 4'hE, 0, 0)));
    foreach (t[k]) begin
      apply(t[k]);
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL halt step %0d got %b want %b", k, got, exp);
      end
    end
    a = 4'hE;
  endtask

  task automatic test_srst();
    vec_t t[$];
    out_t got, exp;
`ifdef SEQ_CTRL_LOOP_EN
    t.push_back(V(8'h35, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 0)));
`endif
    t.push_back(V(8'h60, 1, 0, 0, mk(1, 0, 0, 1, a, 0, 0)));
    t.push_back(V(8'h1F, 1, 0, 1, mk(1, 0, 0, 1, a, 0, 0)));
    t.push_back(V(8'h1F, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 0)));
`ifdef SEQ_CTRL_LOOP_EN
    t.push_back(V(8'h42, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 0)));
`else
    t.push_back(V(8'h42, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 1)));
`endif
    foreach (t[k]) begin
      apply(t[k]);
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL srst step %0d got %b want %b", k, got, exp);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t t[$];
    out_t got, exp;
    t.push_back(V(8'h9F, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 1)));
    t.push_back(V(8'h7F, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 1)));
    t.push_back(V(8'hF1, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 1)));
    t.push_back(V(8'h00, 1, 0, 0, mk(0, 0, 0, 0, a, 0, 0)));
    foreach (t[k]) begin
      apply(t[k]);
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL illegal step %0d got %b want %b", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_abort();
    vec_t t[$];
    out_t got, exp;
    for (int r = 0; r < 2; r++) begin
      t.delete();
      if (r == 0)
        t.push_back(V(8'h1C, 1, 0, 0, mk(0, 1, 0, 0, 4'hC, 0, 0)));
      else
        t.push_back(V(8'h50, 1, 0, 0, mk(0, 0, 0, 1, 4'h0, 1, 0)));
      apply(t[0]);
      exp = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_pre %0d got %b want %b", r, got, exp);
      end
      #2 reset = 1'b1;
      #1;
      got = obs();
      checks++;
      if (got !== mk(1, 0, 0, 1, 4'h0, 0, 0)) begin
        errors++;
        $display("FAIL abort_async %0d got %b want %b", r, got,
                 mk(1, 0, 0, 1, 4'h0, 0, 0));
      end
      @(posedge clk);
      #1 reset = 1'b0;
      t.delete();
      t.push_back(V(8'h9F, 1, 0, 0, mk(1, 0, 0, 1, 4'h0, 0, 0)));
      t.push_back(V(8'h9F, 1, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 0)));
      t.push_back(V(8'h9F, 1, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 1)));
      t.push_back(V(8'h00, 1, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 0)));
      foreach (t[k]) begin
        apply(t[k]);
        exp = sb.pop_front();
        got = obs();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL abort_post %0d step %0d got %b want %b",
                   r, k, got, exp);
        end
      end
    end
    a = 4'h0;
  endtask

  initial begin
    test_reset();
    test_jmp();
    test_jnz();
    test_loop();
    test_halt();
    test_srst();
    test_illegal();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
